// File: rtl/seven_seg_pkg.sv
// Encodings shared by the seven-segment display driver and the capture block:
// segment patterns, one-cold anode codes and small classification helpers.
`timescale 1ns/1ps
package seven_seg_pkg;

  // Active-low one-cold anode codes, slot 3 is the leftmost digit
  localparam logic [3:0] ANODES_SLOT0 = 4'b1110;
  localparam logic [3:0] ANODES_SLOT1 = 4'b1101;
  localparam logic [3:0] ANODES_SLOT2 = 4'b1011;
  localparam logic [3:0] ANODES_SLOT3 = 4'b0111;
  localparam logic [3:0] ANODES_BLANK = 4'b1111;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ANODE_BLANK   = 2'd0,
    ANODE_DIGIT   = 2'd1,
    ANODE_ILLEGAL = 2'd2
  } anode_class_e;

  typedef struct packed {
    logic       match;
    logic [3:0] nibble;
  } seg_decode_t;

  // Nibble to segment pattern, as used by the display driver side
  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      4'hF: pat = SEG_HEX_F;
      default: pat = SEG_ALL_OFF;
    endcase
    return pat;
  endfunction

  // Classify an anode sample as blank, a single legal digit, or illegal
  function automatic anode_class_e anode_classify(input logic [3:0] anodes);
    anode_class_e cls;
    case (anodes)
      ANODES_SLOT0, ANODES_SLOT1, ANODES_SLOT2, ANODES_SLOT3: cls = ANODE_DIGIT;
      ANODES_BLANK: cls = ANODE_BLANK;
      default:      cls = ANODE_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Slot index of a legal one-cold anode code (0 for anything else)
  function automatic logic [1:0] anode_slot(input logic [3:0] anodes);
    logic [1:0] slot;
    case (anodes)
      ANODES_SLOT0: slot = 2'd0;
      ANODES_SLOT1: slot = 2'd1;
      ANODES_SLOT2: slot = 2'd2;
      ANODES_SLOT3: slot = 2'd3;
      default:      slot = 2'd0;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Display bus plus captured-frame outputs of the seven-segment capture block.
`timescale 1ns/1ps
interface seven_seg_capture_if;
  logic [7:0]  segs_in;    // active-low {dp,g,f,e,d,c,b,a}
  logic [3:0]  anodes_in;  // active-low one-cold digit enables
  logic [15:0] data_out;   // last complete frame, [15:12] leftmost
  logic [3:0]  dots_out;   // decimal points, active-high
  logic        valid_out;  // one-cycle frame strobe
  logic        error_out;  // one-cycle illegal-pattern strobe

  modport master (
    output segs_in, anodes_in,
    input  data_out, dots_out, valid_out, error_out
  );

  modport slave (
    input  segs_in, anodes_in,
    output data_out, dots_out, valid_out, error_out
  );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational segment pattern to hex nibble decoder.
`timescale 1ns/1ps
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0]  pattern_i,
  output seg_decode_t decode_o
);

  // Reverse lookup of the shared hex table; anything else is a non-match
  always_comb begin
    decode_o = '{match: 1'b1, nibble: 4'h0};
    case (pattern_i)
      SEG_HEX_0: decode_o.nibble = 4'h0;
      SEG_HEX_1: decode_o.nibble = 4'h1;
      SEG_HEX_2: decode_o.nibble = 4'h2;
      SEG_HEX_3: decode_o.nibble = 4'h3;
      SEG_HEX_4: decode_o.nibble = 4'h4;
      SEG_HEX_5: decode_o.nibble = 4'h5;
      SEG_HEX_6: decode_o.nibble = 4'h6;
      SEG_HEX_7: decode_o.nibble = 4'h7;
      SEG_HEX_8: decode_o.nibble = 4'h8;
      SEG_HEX_9: decode_o.nibble = 4'h9;
      SEG_HEX_A: decode_o.nibble = 4'hA;
      SEG_HEX_B: decode_o.nibble = 4'hB;
      SEG_HEX_C: decode_o.nibble = 4'hC;
      SEG_HEX_D: decode_o.nibble = 4'hD;
      SEG_HEX_E: decode_o.nibble = 4'hE;
      SEG_HEX_F: decode_o.nibble = 4'hF;
      default:   decode_o = '{match: 1'b0, nibble: 4'h0};
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures frames from an active-low multiplexed 4-digit seven-segment bus:
// synchronise, qualify stable digits, decode, and publish complete frames.
`timescale 1ns/1ps
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 16
)
(
  input  logic         clk_in,
  input  logic         reset_in,
  seven_seg_capture_if.slave bus
);

  localparam logic [7:0]  QUAL_LEVEL = 8'(STABLE_COUNT - 1);
  localparam logic [7:0]  CNT_MAX    = 8'hFF;
  localparam logic [11:0] IDLE_BUS   = 12'hFFF;

  // Synchroniser and stability filter
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;
  logic [11:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;

  // Frame assembly
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dots_q, shadow_dots_d;
  logic [3:0]  seen_q, seen_d;

  // Outputs
  logic [15:0] data_q, data_d;
  logic [3:0]  dots_q, dots_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  // Qualified sample view
  logic         qualify_s;
  logic [3:0]   q_anodes_s;
  logic [7:0]   q_segs_s;
  anode_class_e cls_s;
  logic [1:0]   slot_s;
  seg_decode_t  dec_s;
  logic         frame_done_s;
  logic [3:0]   seen_base_s;

  // The qualified pattern is the held previous sample: it is the one the
  // counter has been measuring, even if the bus moves during this cycle.
  assign q_anodes_s   = prev_q[11:8];
  assign q_segs_s     = prev_q[7:0];
  assign qualify_s    = (cnt_q == QUAL_LEVEL);
  assign cls_s        = anode_classify(q_anodes_s);
  assign slot_s       = anode_slot(q_anodes_s);
  assign frame_done_s = (seen_q == 4'hF);

  seven_seg_decode u_decode (
    .pattern_i (q_segs_s[6:0]),
    .decode_o  (dec_s)
  );

  // Two-flop synchroniser followed by the previous-sample register
  always_comb begin
    sync1_d = {bus.anodes_in, bus.segs_in};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Stability counter: restart on any change, otherwise count up and saturate
  always_comb begin
    if (sync2_q != prev_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Frame assembly: a completed frame clears seen first, so a qualify in
  // the publish cycle starts the next frame.  Qualifies are at least two
  // cycles apart, so an error can never land in the publish cycle.
  always_comb begin
    seen_base_s   = frame_done_s ? 4'h0 : seen_q;
    seen_d        = seen_base_s;
    shadow_d      = shadow_q;
    shadow_dots_d = shadow_dots_q;
    error_d       = 1'b0;
    if (qualify_s) begin
      case (cls_s)
        ANODE_DIGIT: begin
          if (dec_s.match) begin
            shadow_d[{slot_s, 2'b00} +: 4] = dec_s.nibble;
            shadow_dots_d[slot_s]          = ~q_segs_s[7];
            seen_d[slot_s]                 = 1'b1;
          end else begin
            error_d = 1'b1;
            seen_d  = 4'h0;
          end
        end
        ANODE_BLANK: begin
          seen_d = seen_base_s;
        end
        default: begin
          error_d = 1'b1;
          seen_d  = 4'h0;
        end
      endcase
    end else begin
      seen_d = seen_base_s;
    end
  end

  // Publish the shadow one cycle after the last slot is seen
  always_comb begin
    valid_d = frame_done_s;
    if (frame_done_s) begin
      data_d = shadow_q;
      dots_d = shadow_dots_q;
    end else begin
      data_d = data_q;
      dots_d = dots_q;
    end
  end

  // State registers; synchroniser idles at all-ones (display dark)
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sync1_q       <= IDLE_BUS;
      sync2_q       <= IDLE_BUS;
      prev_q        <= IDLE_BUS;
      cnt_q         <= 8'd0;
      shadow_q      <= 16'h0000;
      shadow_dots_q <= 4'h0;
      seen_q        <= 4'h0;
      data_q        <= 16'h0000;
      dots_q        <= 4'h0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_dots_q <= shadow_dots_d;
      seen_q        <= seen_d;
      data_q        <= data_d;
      dots_q        <= dots_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.dots_out  = dots_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;

endmodule
